// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode codes and counter sizing.
package shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } mode_e;

  // Counter must represent 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_bitcnt.sv
// Saturating shift counter: clear to full, load to zero, increment up to WIDTH.
module shift_bitcnt import shift_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             empty
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                          cnt_d = CNT_MAX;
    else if (load)                    cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_MAX;
    else        cnt_q <= cnt_d;
  end

  assign cnt   = cnt_q;
  assign empty = (cnt_q == CNT_MAX);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift left / shift right / load) with shift counter.
// Define USHIFT_ROTATE_EN to build rotate-left/right for modes 100/101.
module univ_shift_reg import shift_pkg::*; #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = cnt_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin_l,
  input  logic              sin_r,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              sout_l,
  output logic              sout_r,
  output logic [CNT_W-1:0]  cnt,
  output logic              empty
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             load, inc;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Data mux and counter strobes come from one decode so they always move together.
  always_comb begin
    q_d  = q_q;
    load = 1'b0;
    inc  = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      case (mode_s)
        MODE_SHL: begin
          q_d = {q_q[WIDTH-2:0], sin_l};
          inc = 1'b1;
        end
        MODE_SHR: begin
          q_d = {sin_r, q_q[WIDTH-1:1]};
          inc = 1'b1;
        end
        MODE_LOAD: begin
          q_d  = d;
          load = 1'b1;
        end
`ifdef USHIFT_ROTATE_EN
        MODE_ROL: begin
          q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          inc = 1'b1;
        end
        MODE_ROR: begin
          q_d = {q_q[0], q_q[WIDTH-1:1]};
          inc = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  shift_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .inc   (inc),
    .cnt   (cnt),
    .empty (empty)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule
